zap_branch_predict_ctrl: RTL and testbench

- Controller in front of the 2-bit branch-history block RAM (one registered read port, one write port, NUMBER_OF_ENTRIES entries).
- Sequences fetch-side lookups and resolve-side saturating-counter updates.
- Performs a hardware clear sweep after reset and on flush, so the RAM needs no reset loop.
- Sits between the fetch/decode stages and the RAM.

---
 rtl/zap_bp_pkg.sv | 28 ++
 rtl/zap_bp_clear_seq.sv | 54 +++++
 rtl/zap_branch_predict_ctrl.sv | 138 +++++++++++++
 tb/tb_zap_branch_predict_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/zap_bp_pkg.sv
// Shared definitions for the branch-predictor RAM controller: counter
// encodings, controller FSM states and the 2-bit saturating update rule.
package zap_bp_pkg;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   typedef enum logic [0:0] {
      BP_CLEAR = 1'b0,
      BP_RUN   = 1'b1
   } bp_state_t;

   function automatic logic [1:0] bp_next_state(input logic [1:0] state, input logic taken);
      logic [1:0] nxt;
      nxt = state;
      if (taken) begin
         if (state != ST) nxt = state + 2'd1;
         else             nxt = ST;
      end else begin
         if (state != SNT) nxt = state - 2'd1;
         else              nxt = SNT;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/zap_bp_clear_seq.sv
// Clear-sweep sequencer: owns the CLEAR/RUN state and the sweep address,
// restarting from address 0 on reset or flush.
module zap_bp_clear_seq
   import zap_bp_pkg::*;
#(
   parameter int NUMBER_OF_ENTRIES = 64,
   localparam int IW = $clog2(NUMBER_OF_ENTRIES)
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_flush,
   output bp_state_t     o_state,
   output logic [IW-1:0] o_clr_cnt
);

   localparam logic [IW-1:0] CLR_LAST = IW'(NUMBER_OF_ENTRIES - 1);
   localparam logic [IW-1:0] CLR_ONE  = IW'(1);

   bp_state_t     state_r;
   logic [IW-1:0] clr_cnt_r;

   // Sweep FSM: one clear write per CLEAR cycle, then park in RUN.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r   <= BP_CLEAR;
         clr_cnt_r <= {IW{1'b0}};
      end else if (i_flush) begin
         state_r   <= BP_CLEAR;
         clr_cnt_r <= {IW{1'b0}};
      end else begin
         case (state_r)
            BP_CLEAR: begin
               if (clr_cnt_r == CLR_LAST) begin
                  state_r   <= BP_RUN;
                  clr_cnt_r <= {IW{1'b0}};
               end else begin
                  clr_cnt_r <= clr_cnt_r + CLR_ONE;
               end
            end
            BP_RUN: begin
               clr_cnt_r <= {IW{1'b0}};
            end
            default: begin
               state_r   <= BP_CLEAR;
               clr_cnt_r <= {IW{1'b0}};
            end
         endcase
      end
   end

   assign o_state   = state_r;
   assign o_clr_cnt = clr_cnt_r;

endmodule

// File: rtl/zap_branch_predict_ctrl.sv
// Branch-history RAM controller: fetch lookups, saturating-counter updates and
// hardware clear sweep. Define ZAP_BP_FWD_EN to forward same-cycle writes to lookups.
module zap_branch_predict_ctrl
   import zap_bp_pkg::*;
#(
   parameter int NUMBER_OF_ENTRIES = 64,
   parameter int PC_LSB = 2,
   localparam int IW = $clog2(NUMBER_OF_ENTRIES)
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_lkp_valid,
   input  logic [31:0]   i_lkp_pc,
   output logic          o_pred_valid,
   output logic [1:0]    o_pred_state,
   input  logic          i_upd_valid,
   input  logic [31:0]   i_upd_pc,
   input  logic [1:0]    i_upd_state,
   input  logic          i_upd_taken,
   input  logic          i_flush,
   output logic          o_busy,
   output logic [IW-1:0] o_ram_rd_addr,
   input  logic [1:0]    i_ram_rd_data,
   output logic          o_ram_wr_en,
   output logic [IW-1:0] o_ram_wr_addr,
   output logic [1:0]    o_ram_wr_data
);

   bp_state_t     state_s;
   logic [IW-1:0] clr_cnt_s;
   logic [IW-1:0] lkp_idx_s;
   logic [IW-1:0] upd_idx_s;
   logic          busy_s;
   logic          unused_s;

   logic          wr_en_nxt_s;
   logic [IW-1:0] wr_addr_nxt_s;
   logic [1:0]    wr_data_nxt_s;
   logic [1:0]    pred_state_s;

   logic          wr_en_r;
   logic [IW-1:0] wr_addr_r;
   logic [1:0]    wr_data_r;
   logic          pred_valid_r;
   logic          lkp_busy_r;

   zap_bp_clear_seq #(
      .NUMBER_OF_ENTRIES(NUMBER_OF_ENTRIES)
   ) u_clear_seq (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_flush   (i_flush),
      .o_state   (state_s),
      .o_clr_cnt (clr_cnt_s)
   );

   assign busy_s    = (state_s == BP_CLEAR);
   assign lkp_idx_s = i_lkp_pc[PC_LSB+IW-1:PC_LSB];
   assign upd_idx_s = i_upd_pc[PC_LSB+IW-1:PC_LSB];
   assign unused_s  = ^{i_lkp_pc, i_upd_pc};

   // Write-port arbitration: flush silences the port, clear sweep beats updates.
   always_comb begin
      wr_en_nxt_s   = 1'b0;
      wr_addr_nxt_s = {IW{1'b0}};
      wr_data_nxt_s = SNT;
      if (i_flush) begin
         wr_en_nxt_s = 1'b0;
      end else if (busy_s) begin
         wr_en_nxt_s   = 1'b1;
         wr_addr_nxt_s = clr_cnt_s;
         wr_data_nxt_s = SNT;
      end else if (i_upd_valid) begin
         wr_en_nxt_s   = 1'b1;
         wr_addr_nxt_s = upd_idx_s;
         wr_data_nxt_s = bp_next_state(i_upd_state, i_upd_taken);
      end else begin
         wr_en_nxt_s = 1'b0;
      end
   end

   // Registered write port and lookup-response qualifiers.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_en_r      <= 1'b0;
         wr_addr_r    <= {IW{1'b0}};
         wr_data_r    <= SNT;
         pred_valid_r <= 1'b0;
         lkp_busy_r   <= 1'b1;
      end else begin
         wr_en_r      <= wr_en_nxt_s;
         wr_addr_r    <= wr_addr_nxt_s;
         wr_data_r    <= wr_data_nxt_s;
         pred_valid_r <= i_lkp_valid;
         lkp_busy_r   <= busy_s;
      end
   end

`ifdef ZAP_BP_FWD_EN
   logic       fwd_hit_r;
   logic [1:0] fwd_data_r;

   // The RAM reads before it writes, so capture any same-address write for next cycle.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         fwd_hit_r  <= 1'b0;
         fwd_data_r <= SNT;
      end else begin
         fwd_hit_r  <= wr_en_r && (wr_addr_r == lkp_idx_s);
         fwd_data_r <= wr_data_r;
      end
   end

   // Prediction select: forced SNT while clearing, else forwarded or RAM data.
   always_comb begin
      pred_state_s = SNT;
      if (lkp_busy_r)     pred_state_s = SNT;
      else if (fwd_hit_r) pred_state_s = fwd_data_r;
      else                pred_state_s = i_ram_rd_data;
   end
`else
   // Prediction select: forced SNT while clearing, else RAM data as read.
   always_comb begin
      pred_state_s = SNT;
      if (lkp_busy_r) pred_state_s = SNT;
      else            pred_state_s = i_ram_rd_data;
   end
`endif

   assign o_ram_rd_addr = lkp_idx_s;
   assign o_ram_wr_en   = wr_en_r;
   assign o_ram_wr_addr = wr_addr_r;
   assign o_ram_wr_data = wr_data_r;
   assign o_pred_valid  = pred_valid_r;
   assign o_pred_state  = pred_state_s;
   assign o_busy        = busy_s;

endmodule

// File: tb/tb_zap_branch_predict_ctrl.sv
// Directed bench for zap_branch_predict_ctrl with a behavioural 2-bit RAM
// (registered read, read-before-write); expectations follow ZAP_BP_FWD_EN.
module tb_zap_branch_predict_ctrl;

   localparam int IW = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          lkp_valid;
   logic [31:0]   lkp_pc;
   logic          pred_valid;
   logic [1:0]    pred_state;
   logic          upd_valid;
   logic [31:0]   upd_pc;
   logic [1:0]    upd_state;
   logic          upd_taken;
   logic          flush;
   logic          busy;
   logic [IW-1:0] rd_addr;
   logic [1:0]    rd_data;
   logic          wr_en;
   logic [IW-1:0] wr_addr;
   logic [1:0]    wr_data;

   logic [1:0]    mem [64];

   int total = 0;
   int bad   = 0;
   int cyc;
   int wr_bad;

   always #5 clk = ~clk;

   zap_branch_predict_ctrl dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .i_lkp_valid   (lkp_valid),
      .i_lkp_pc      (lkp_pc),
      .o_pred_valid  (pred_valid),
      .o_pred_state  (pred_state),
      .i_upd_valid   (upd_valid),
      .i_upd_pc      (upd_pc),
      .i_upd_state   (upd_state),
      .i_upd_taken   (upd_taken),
      .i_flush       (flush),
      .o_busy        (busy),
      .o_ram_rd_addr (rd_addr),
      .i_ram_rd_data (rd_data),
      .o_ram_wr_en   (wr_en),
      .o_ram_wr_addr (wr_addr),
      .o_ram_wr_data (wr_data)
   );

   always @(posedge clk) begin
      rd_data <= mem[rd_addr];
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic upd(input logic v, input logic [31:0] pc, input logic [1:0] st, input logic tk);
      upd_valid = v;
      upd_pc    = pc;
      upd_state = st;
      upd_taken = tk;
   endtask

   initial begin
      rst_n = 1'b0; lkp_valid = 1'b0; lkp_pc = 32'h0; flush = 1'b0;
      upd(1'b0, 32'h0, 2'b00, 1'b0);

      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd1);
      check("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
      check("rst_pred_state", {30'd0, pred_state}, 32'd0);
      check("rst_wr_en", {31'd0, wr_en}, 32'd0);
      rst_n = 1'b1;

      // initial sweep: 64 busy samples, writes 0..63 of 00
      cyc = 0; wr_bad = 0;
      while (busy && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (!(wr_en === 1'b1 && wr_addr === IW'(cyc - 1) && wr_data === 2'b00)) wr_bad++;
      end
      check("sweep_len", cyc, 32'd64);
      check("sweep_writes", wr_bad, 32'd0);

      lkp_valid = 1'b1; lkp_pc = 32'h100;
      @(negedge clk);
      check("lkp_valid", {31'd0, pred_valid}, 32'd1);
      check("lkp_state", {30'd0, pred_state}, 32'd0);
      check("idle_wr_en", {31'd0, wr_en}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      lkp_valid = 1'b0;

      // pc 0x100 -> index 0: 00 -> 01 -> 10 -> 11, saturate, then not-taken
      upd(1'b1, 32'h100, 2'b00, 1'b1);
      @(negedge clk);
      check("upd1", {25'd0, wr_en, wr_addr, wr_data}, {25'd0, 1'b1, 6'd0, 2'b01});
      upd(1'b1, 32'h100, 2'b01, 1'b1);
      @(negedge clk);
      check("upd2", {25'd0, wr_en, wr_addr, wr_data}, {25'd0, 1'b1, 6'd0, 2'b10});
      upd(1'b1, 32'h100, 2'b10, 1'b1);
      @(negedge clk);
      check("upd3", {25'd0, wr_en, wr_addr, wr_data}, {25'd0, 1'b1, 6'd0, 2'b11});
      upd(1'b1, 32'h100, 2'b11, 1'b1);
      @(negedge clk);
      check("upd_sat", {25'd0, wr_en, wr_addr, wr_data}, {25'd0, 1'b1, 6'd0, 2'b11});
      upd(1'b1, 32'h100, 2'b11, 1'b0);
      @(negedge clk);
      check("upd_nt", {25'd0, wr_en, wr_addr, wr_data}, {25'd0, 1'b1, 6'd0, 2'b10});
      upd(1'b0, 32'h0, 2'b00, 1'b0);
      @(negedge clk);
      check("upd_idle", {31'd0, wr_en}, 32'd0);
      lkp_valid = 1'b1; lkp_pc = 32'h100;
      @(negedge clk);
      check("lkp_after_upd", {30'd0, pred_state}, 32'd2);
      lkp_valid = 1'b0;

      // pc 0x104 -> index 1: set to 01, then 01->10 one cycle before a lookup
      upd(1'b1, 32'h104, 2'b00, 1'b1);
      @(negedge clk);
      check("fwd_pre_wr", {25'd0, wr_en, wr_addr, wr_data}, {25'd0, 1'b1, 6'd1, 2'b01});
      upd(1'b1, 32'h104, 2'b01, 1'b1);
      @(negedge clk);
      upd(1'b0, 32'h0, 2'b00, 1'b0);
      lkp_valid = 1'b1; lkp_pc = 32'h104;
      @(negedge clk);
      check("fwd_valid", {31'd0, pred_valid}, 32'd1);
`ifdef ZAP_BP_FWD_EN
      check("fwd_state", {30'd0, pred_state}, 32'd2);
`else
      check("fwd_state", {30'd0, pred_state}, 32'd1);
`endif
      lkp_valid = 1'b0;

      // flush with a simultaneous update in RUN
      flush = 1'b1;
      upd(1'b1, 32'h108, 2'b10, 1'b1);
      @(negedge clk);
      check("flush_no_wr", {31'd0, wr_en}, 32'd0);
      check("flush_busy", {31'd0, busy}, 32'd1);
      flush = 1'b0;
      upd(1'b0, 32'h0, 2'b00, 1'b0);
      @(negedge clk);
      check("flush_first_clr", {25'd0, wr_en, wr_addr, wr_data}, {25'd0, 1'b1, 6'd0, 2'b00});

      // flush at sweep count 30, with an update held across the new sweep
      repeat (29) @(negedge clk);
      check("pre_flush_addr", {26'd0, wr_addr}, 32'd29);
      flush = 1'b1;
      upd(1'b1, 32'h108, 2'b10, 1'b1);
      @(negedge clk);
      check("midflush_no_wr", {31'd0, wr_en}, 32'd0);
      flush = 1'b0;
      cyc = 0; wr_bad = 0;
      while (busy && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (!(wr_en === 1'b1 && wr_addr === IW'(cyc - 1) && wr_data === 2'b00)) wr_bad++;
      end
      upd(1'b0, 32'h0, 2'b00, 1'b0);
      check("resweep_len", cyc, 32'd64);
      check("resweep_writes", wr_bad, 32'd0);

      // reset while an update write is on the port
      upd(1'b1, 32'h100, 2'b00, 1'b1);
      @(negedge clk);
      check("pre_rst_wr", {31'd0, wr_en}, 32'd1);
      upd(1'b0, 32'h0, 2'b00, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_wr_en", {31'd0, wr_en}, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_first_clr", {25'd0, wr_en, wr_addr, wr_data}, {25'd0, 1'b1, 6'd0, 2'b00});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
